// File: rtl/axis_pkt_arbiter.sv
// Two-input packet-granular AXI4-Stream arbiter with round-robin fairness,
// per-grant packet bursts and per-input completed-packet counters.
module axis_pkt_arbiter #(
    parameter int unsigned DATA_WIDTH = 512
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     AXIS_IN0_TDATA,
    input  logic [DATA_WIDTH/8-1:0]   AXIS_IN0_TKEEP,
    input  logic                      AXIS_IN0_TLAST,
    input  logic                      AXIS_IN0_TVALID,
    output logic                      AXIS_IN0_TREADY,
    input  logic [DATA_WIDTH-1:0]     AXIS_IN1_TDATA,
    input  logic [DATA_WIDTH/8-1:0]   AXIS_IN1_TKEEP,
    input  logic                      AXIS_IN1_TLAST,
    input  logic                      AXIS_IN1_TVALID,
    output logic                      AXIS_IN1_TREADY,
    output logic [DATA_WIDTH-1:0]     AXIS_OUT_TDATA,
    output logic [DATA_WIDTH/8-1:0]   AXIS_OUT_TKEEP,
    output logic                      AXIS_OUT_TLAST,
    output logic                      AXIS_OUT_TVALID,
    input  logic                      AXIS_OUT_TREADY,
    input  logic [1:0]                ENABLE,
    input  logic [7:0]                BURST_PKTS,
    input  logic                      CLEAR_COUNTS,
    output logic [31:0]               PKT_COUNT0,
    output logic [31:0]               PKT_COUNT1,
    output logic [1:0]                GRANT
);

    typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic [7:0]  burst_cnt_q, burst_cnt_d;
    logic [31:0] pkt_count0_q, pkt_count0_d;
    logic [31:0] pkt_count1_q, pkt_count1_d;

    logic [1:0]  req;
    logic [8:0]  burst_max;
    logic        burst_more;
    logic        sel;
    logic        last_hs;

    assign req        = ENABLE & {AXIS_IN1_TVALID, AXIS_IN0_TVALID};
    assign burst_max  = (BURST_PKTS == 8'd0) ? 9'd1 : {1'b0, BURST_PKTS};
    assign burst_more = ({1'b0, burst_cnt_q} + 9'd1) < burst_max;

    always_comb begin
        state_d         = state_q;
        last_d          = last_q;
        burst_cnt_d     = burst_cnt_q;
        pkt_count0_d    = pkt_count0_q;
        pkt_count1_d    = pkt_count1_q;
        sel             = 1'b0;
        last_hs         = 1'b0;
        AXIS_IN0_TREADY = 1'b0;
        AXIS_IN1_TREADY = 1'b0;
        AXIS_OUT_TDATA  = '0;
        AXIS_OUT_TKEEP  = '0;
        AXIS_OUT_TLAST  = 1'b0;
        AXIS_OUT_TVALID = 1'b0;

        unique case (state_q)
            StIdle: begin
                // On a tie, serve the input that was not served most recently
                if (req == 2'b11)  state_d = last_q ? StGrant0 : StGrant1;
                else if (req[0])   state_d = StGrant0;
                else if (req[1])   state_d = StGrant1;
            end
            StGrant0, StGrant1: begin
                sel = (state_q == StGrant1);
                if (sel) begin
                    AXIS_OUT_TDATA  = AXIS_IN1_TDATA;
                    AXIS_OUT_TKEEP  = AXIS_IN1_TKEEP;
                    AXIS_OUT_TLAST  = AXIS_IN1_TLAST;
                    AXIS_OUT_TVALID = AXIS_IN1_TVALID;
                    AXIS_IN1_TREADY = AXIS_OUT_TREADY;
                    last_hs         = AXIS_IN1_TVALID & AXIS_OUT_TREADY & AXIS_IN1_TLAST;
                end else begin
                    AXIS_OUT_TDATA  = AXIS_IN0_TDATA;
                    AXIS_OUT_TKEEP  = AXIS_IN0_TKEEP;
                    AXIS_OUT_TLAST  = AXIS_IN0_TLAST;
                    AXIS_OUT_TVALID = AXIS_IN0_TVALID;
                    AXIS_IN0_TREADY = AXIS_OUT_TREADY;
                    last_hs         = AXIS_IN0_TVALID & AXIS_OUT_TREADY & AXIS_IN0_TLAST;
                end

                if (last_hs) begin
                    last_d = sel;
                    if (sel) pkt_count1_d = pkt_count1_q + 32'd1;
                    else     pkt_count0_d = pkt_count0_q + 32'd1;
                    // Unfinished burst holds the grant even if the input goes quiet
                    if (burst_more && ENABLE[sel]) begin
                        burst_cnt_d = burst_cnt_q + 8'd1;
                    end else begin
                        burst_cnt_d = 8'd0;
                        if (req[~sel])     state_d = sel ? StGrant0 : StGrant1;
                        else if (req[sel]) state_d = state_q;
                        else               state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (CLEAR_COUNTS) begin
            pkt_count0_d = 32'd0;
            pkt_count1_d = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_q       <= 1'b1;
            burst_cnt_q  <= 8'd0;
            pkt_count0_q <= 32'd0;
            pkt_count1_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            burst_cnt_q  <= burst_cnt_d;
            pkt_count0_q <= pkt_count0_d;
            pkt_count1_q <= pkt_count1_d;
        end
    end

    assign PKT_COUNT0 = pkt_count0_q;
    assign PKT_COUNT1 = pkt_count1_q;
    assign GRANT      = {state_q == StGrant1, state_q == StGrant0};

endmodule
